// File: rtl/fp_add_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point adder.
// The slave side is the adder; the master side feeds operands and drains results.
interface fp_add_sub_pipe_if #(
  parameter int EW = 8,
  parameter int MW = 7
);
  localparam int W = 1 + EW + MW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cntl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic [3:0]   flags;

  modport slave (
    input  in_valid, a, b, cntl, out_ready,
    output in_ready, out_valid, c, flags
  );

  modport master (
    output in_valid, a, b, cntl, out_ready,
    input  in_ready, out_valid, c, flags
  );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// Three-stage pipelined floating-point add/subtract (bfloat16 by default).
// Subnormals flush to zero; rounding is round-to-nearest, ties-to-even.
module fp_add_sub_pipe #(
  parameter int EW = 8,
  parameter int MW = 7
) (
  input  logic             clk,
  input  logic             rst,
  fp_add_sub_pipe_if.slave bus
);
  localparam int W   = 1 + EW + MW;
  localparam int N   = MW + 4;
  localparam int AW  = 2 * (MW + 3);
  localparam int XW  = EW + 2;
  localparam int LZW = $clog2(N + 1);
  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic [EW-1:0] SH_MAX   = EW'(MW + 3);
  localparam logic [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);

  logic          s1Valid_q;
  logic          s1Sign_q,   s1Sign_d;
  logic          s1Sub_q,    s1Sub_d;
  logic [EW-1:0] s1Exp_q,    s1Exp_d;
  logic [MW:0]   s1SigL_q,   s1SigL_d;
  logic [MW+2:0] s1SigS_q,   s1SigS_d;
  logic          s1Sticky_q, s1Sticky_d;
  logic          s1Spec_q,   s1Spec_d;
  logic [W-1:0]  s1SpecC_q,  s1SpecC_d;
  logic          s1SpecInv_q, s1SpecInv_d;

  logic          s2Valid_q;
  logic          s2Sign_q;
  logic [XW-1:0] s2Exp_q,    s2Exp_d;
  logic [N-1:0]  s2Norm_q,   s2Norm_d;
  logic          s2Zero_q,   s2Zero_d;
  logic          s2Spec_q;
  logic [W-1:0]  s2SpecC_q;
  logic          s2SpecInv_q;

  logic          outValid_q;
  logic [W-1:0]  c_q,        s3C_d;
  logic [3:0]    flags_q,    s3Flags_d;

  logic          adv;

  assign adv           = !outValid_q || bus.out_ready;
  assign bus.in_ready  = rst || adv;
  assign bus.out_valid = outValid_q;
  assign bus.c         = c_q;
  assign bus.flags     = flags_q;

  logic              sa, sb;
  logic              nanA, nanB, infA, infB, zeroA, zeroB, aBig;
  logic [EW-1:0]     ea, eb, expDiff, shAmt;
  logic [MW-1:0]     ma, mb;
  logic [EW+MW-1:0]  keyA, keyB;
  logic [MW:0]       sigA, sigB, sigS;
  logic [AW-1:0]     alignWide;

  // Stage 1: the larger magnitude becomes L so the difference is never negative.
  always_comb begin
    sa    = bus.a[W-1];
    ea    = bus.a[W-2:MW];
    ma    = bus.a[MW-1:0];
    sb    = bus.b[W-1] ^ bus.cntl;
    eb    = bus.b[W-2:MW];
    mb    = bus.b[MW-1:0];
    nanA  = (ea == EXP_ONES) && (ma != '0);
    nanB  = (eb == EXP_ONES) && (mb != '0);
    infA  = (ea == EXP_ONES) && (ma == '0);
    infB  = (eb == EXP_ONES) && (mb == '0);
    zeroA = (ea == '0);
    zeroB = (eb == '0);
    sigA  = zeroA ? '0 : {1'b1, ma};
    sigB  = zeroB ? '0 : {1'b1, mb};
    keyA  = {ea, (zeroA ? {MW{1'b0}} : ma)};
    keyB  = {eb, (zeroB ? {MW{1'b0}} : mb)};
    aBig  = (keyA >= keyB);

    s1Sign_d = aBig ? sa : sb;
    s1Sub_d  = sa ^ sb;
    s1Exp_d  = aBig ? ea : eb;
    s1SigL_d = aBig ? sigA : sigB;
    sigS     = aBig ? sigB : sigA;
    expDiff  = aBig ? (ea - eb) : (eb - ea);
    shAmt    = (expDiff > SH_MAX) ? SH_MAX : expDiff;

    alignWide  = {sigS, 2'b00, {(MW + 3){1'b0}}} >> shAmt;
    s1SigS_d   = alignWide[AW-1:MW+3];
    s1Sticky_d = |alignWide[MW+2:0];

    s1Spec_d    = 1'b0;
    s1SpecC_d   = '0;
    s1SpecInv_d = 1'b0;
    if (nanA || nanB || (infA && infB && (sa != sb))) begin
      s1Spec_d    = 1'b1;
      s1SpecC_d   = '1;
      s1SpecInv_d = 1'b1;
    end else if (infA) begin
      s1Spec_d  = 1'b1;
      s1SpecC_d = {sa, EXP_ONES, {MW{1'b0}}};
    end else if (infB) begin
      s1Spec_d  = 1'b1;
      s1SpecC_d = {sb, EXP_ONES, {MW{1'b0}}};
    end else if (zeroA && zeroB) begin
      s1Spec_d  = 1'b1;
      s1SpecC_d = {sa & sb, {(EW + MW){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
    end else if (adv) begin
      s1Valid_q   <= bus.in_valid;
      s1Sign_q    <= s1Sign_d;
      s1Sub_q     <= s1Sub_d;
      s1Exp_q     <= s1Exp_d;
      s1SigL_q    <= s1SigL_d;
      s1SigS_q    <= s1SigS_d;
      s1Sticky_q  <= s1Sticky_d;
      s1Spec_q    <= s1Spec_d;
      s1SpecC_q   <= s1SpecC_d;
      s1SpecInv_q <= s1SpecInv_d;
    end
  end

  logic [N-1:0]   opL, opS;
  logic [N:0]     sum;
  logic [LZW-1:0] lzc;
  logic           found;

  // Stage 2: the sticky bit takes part in the subtraction as an ordinary LSB,
  // which keeps the remainder indication exact after a one-place renormalise.
  always_comb begin
    opL = {s1SigL_q, 3'b000};
    opS = {s1SigS_q, s1Sticky_q};
    sum = s1Sub_q ? ({1'b0, opL} - {1'b0, opS}) : ({1'b0, opL} + {1'b0, opS});

    lzc   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lzc   = lzc + LZW'(1);
      end
    end

    s2Zero_d = (sum == '0);
    if (sum[N]) begin
      s2Norm_d = {sum[N:2], |sum[1:0]};
      s2Exp_d  = {2'b00, s1Exp_q} + XW'(1);
    end else begin
      s2Norm_d = sum[N-1:0] << lzc;
      s2Exp_d  = {2'b00, s1Exp_q} - {{(XW - LZW){1'b0}}, lzc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
    end else if (adv) begin
      s2Valid_q   <= s1Valid_q;
      s2Sign_q    <= s1Sign_q;
      s2Exp_q     <= s2Exp_d;
      s2Norm_q    <= s2Norm_d;
      s2Zero_q    <= s2Zero_d;
      s2Spec_q    <= s1Spec_q;
      s2SpecC_q   <= s1SpecC_q;
      s2SpecInv_q <= s1SpecInv_q;
    end
  end

  logic [MW:0]   mant;
  logic          gBit, rBit, sBit, rndUp, inexact;
  logic [MW+1:0] mantR;
  logic [XW-1:0] expR;
  logic [MW-1:0] frac;

  // Stage 3: exponent range is judged after rounding so a carry can rescue it.
  always_comb begin
    mant    = s2Norm_q[N-1:3];
    gBit    = s2Norm_q[2];
    rBit    = s2Norm_q[1];
    sBit    = s2Norm_q[0];
    rndUp   = gBit & (rBit | sBit | mant[0]);
    inexact = gBit | rBit | sBit;
    mantR   = {1'b0, mant} + {{(MW + 1){1'b0}}, rndUp};
    expR    = s2Exp_q + (mantR[MW+1] ? XW'(1) : XW'(0));
    frac    = mantR[MW+1] ? mantR[MW:1] : mantR[MW-1:0];

    s3C_d     = {s2Sign_q, expR[EW-1:0], frac};
    s3Flags_d = {3'b000, inexact};
    if (s2Spec_q) begin
      s3C_d     = s2SpecC_q;
      s3Flags_d = {s2SpecInv_q, 3'b000};
    end else if (s2Zero_q) begin
      s3C_d     = '0;
      s3Flags_d = '0;
    end else if (expR[XW-1] || (expR == '0)) begin
      s3C_d     = {s2Sign_q, {(EW + MW){1'b0}}};
      s3Flags_d = 4'b0011;
    end else if (expR >= EXP_MAX) begin
      s3C_d     = {s2Sign_q, EXP_ONES, {MW{1'b0}}};
      s3Flags_d = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      c_q        <= '0;
      flags_q    <= '0;
    end else if (adv) begin
      outValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        c_q     <= s3C_d;
        flags_q <= s3Flags_d;
      end
    end
  end
endmodule

// File: doc/fp_add_sub_pipe.md
FP_ADD_SUB_PIPE -- requirements
Module: fp_add_sub_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width.
REQ-002 SHALL have parameter MW, default 7, stored mantissa width; W=1+EW+MW, default bfloat16.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  operand pair accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  W  operand A, {sign, exp, mantissa}.
REQ-008 SHALL have port b  input  W  operand B.
REQ-009 SHALL have port cntl  input  1  0 = a+b, 1 = a-b; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  result c valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts c when out_valid && out_ready.
REQ-012 SHALL have port c  output  W  registered result.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, aligned with c.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/swap/align, S2 add-or-subtract/normalise, S3 round/pack/special-select; each stage has a valid bit.
REQ-015 SHALL use a single advance enable adv = !out_valid || out_ready; all stages shift only when adv=1; in_ready = adv.
REQ-016 SHALL give latency of exactly 3 cycles from acceptance to out_valid with out_ready held high; throughput 1 op/cycle.
REQ-017 SHALL hold c, flags, out_valid stable while out_valid && !out_ready; no result lost or duplicated; order preserved.
REQ-018 SHALL propagate bubbles (in_valid=0 on an adv cycle) as invalid stages; no bubble collapsing.
REQ-019 SHALL invert b sign when cntl=1, then treat larger-magnitude operand (exp, then mantissa compare) as A; result sign is A sign.
REQ-020 SHALL align with a right shift of B significand by exp difference into MW+1 bits plus guard, round and sticky; sticky = OR of all bits shifted past round; shift >= MW+3 leaves only sticky.
REQ-021 SHALL, for effective subtraction, normalise with leading-zero count over full width, decrementing exponent per shift.
REQ-022 SHALL round to nearest, ties to even; mantissa carry-out after rounding increments exponent.
REQ-023 SHALL flush subnormal inputs (exp=0) to signed zero before operation.
REQ-024 SHALL flush any result with biased exponent <= 0 to signed zero, setting underflow and inexact.
REQ-025 SHALL produce signed infinity (exp all ones, mantissa 0) with overflow and inexact on exponent overflow.
REQ-026 SHALL return canonical NaN (all W bits 1) with invalid=1 for any NaN input or inf minus inf (after cntl applied).
REQ-027 SHALL pass inf operand through with its effective sign when other operand is finite; inf+inf same sign gives that inf.
REQ-028 SHALL give +0 for exact-zero results of x+(-x) and +0+(-0); -0 only when both effective operands are -0.
REQ-029 SHALL set inexact when any of guard/round/sticky is nonzero before rounding; flags 0 otherwise.

Reset
REQ-030 SHALL, on clk edge with rst=1, clear all stage valid bits, out_valid=0, c=0, flags=0; in-flight operations discarded.
REQ-031 SHALL drive in_ready=1 during and immediately after reset (adv=1 with out_valid=0); operands presented with rst=1 are not accepted.

Verification
REQ-032 SHALL verify: a=0x3F80, b=0x4000, cntl=0 -> c=0x4040, flags=0, out_valid exactly 3 cycles after acceptance.
REQ-033 SHALL verify: a=0x3F80, b=0x3F80, cntl=1 -> c=0x0000; a=0x8000, b=0x0000, cntl=1 -> c=0x8000.
REQ-034 SHALL verify: a=0x3F81, b=0x3B80, cntl=0 (tie) -> c=0x3F82, inexact=1; a=0x3F80, b=0x3B80 -> c=0x3F80, inexact=1.
REQ-035 SHALL verify: a=0x7F80, b=0x7F80, cntl=1 -> c=0xFFFF, invalid=1; a=0x7F7F, b=0x7F7F, cntl=0 -> c=0x7F80, overflow=1, inexact=1.
REQ-036 SHALL verify: 10 back-to-back ops with out_ready low for 5 cycles mid-stream -> in_ready low while out_valid && !out_ready, all 10 results in order, none lost.
REQ-037 SHALL verify: rst asserted one cycle with 2 ops in flight -> out_valid=0 next cycle, the 2 ops never emerge, next accepted op completes normally.
